// File: rtl/prefetch_ar_arbiter.sv
// prefetch_ar_arbiter: single-outstanding AR arbiter between demand and prefetch
// requesters, with starvation protection and a prefetch outstanding window.
`default_nettype none

module prefetch_ar_arbiter #(
  parameter int ADDR_BITS       = 64,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int TID_WIDTH       = 8,
  parameter int LOG_QUEUE_SIZE  = 6,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       ctrlFlush,
  input  logic                       d_valid,
  output logic                       d_ready,
  input  logic [ADDR_BITS-1:0]       d_addr,
  input  logic [BURST_LEN_WIDTH-1:0] d_len,
  input  logic [TID_WIDTH-1:0]       d_id,
  input  logic                       p_valid,
  output logic                       p_ready,
  input  logic [ADDR_BITS-1:0]       p_addr,
  input  logic [BURST_LEN_WIDTH-1:0] p_len,
  input  logic [TID_WIDTH-1:0]       p_id,
  output logic                       m_ar_valid,
  input  logic                       m_ar_ready,
  output logic [ADDR_BITS-1:0]       m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0] m_ar_len,
  output logic [TID_WIDTH-1:0]       m_ar_id,
  output logic                       m_ar_is_pf,
  input  logic                       pf_done,
  input  logic [LOG_QUEUE_SIZE:0]    windowSize,
  output logic [LOG_QUEUE_SIZE:0]    pf_outstanding
);

  localparam int CW = LOG_QUEUE_SIZE + 1;
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] C_STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE_D = 2'd1,
    ISSUE_P = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic [SW-1:0]              r_starve;
  logic [CW-1:0]              r_cnt;
  logic [ADDR_BITS-1:0]       r_addr;
  logic [BURST_LEN_WIDTH-1:0] r_len;
  logic [TID_WIDTH-1:0]       r_id;
  logic                       r_is_pf;
  logic                       w_pf_elig;
  logic                       w_starved;
  logic                       w_grant_d;
  logic                       w_grant_p;
  logic                       w_hs;
  logic                       w_inc;
  logic                       w_dec;

  assign w_pf_elig = p_valid && !ctrlFlush && (r_cnt < windowSize);
  assign w_starved = (r_starve >= C_STARVE_MAX);

  always_comb begin
    w_next    = r_state;
    w_grant_d = 1'b0;
    w_grant_p = 1'b0;
    case (r_state)
      IDLE: begin
        if (en && !reset) begin
          // An eligible prefetch passed over STARVE_LIMIT times takes priority.
          if (d_valid && !(w_pf_elig && w_starved)) begin
            w_grant_d = 1'b1;
            w_next    = ISSUE_D;
          end else if (w_pf_elig) begin
            w_grant_p = 1'b1;
            w_next    = ISSUE_P;
          end
        end
      end
      ISSUE_D, ISSUE_P: begin
        if (m_ar_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign d_ready        = w_grant_d;
  assign p_ready        = w_grant_p;
  assign m_ar_valid     = (r_state != IDLE) && !reset;
  assign m_ar_is_pf     = r_is_pf && m_ar_valid;
  assign m_ar_addr      = r_addr;
  assign m_ar_len       = r_len;
  assign m_ar_id        = r_id;
  assign pf_outstanding = r_cnt;

  assign w_hs  = m_ar_valid && m_ar_ready;
  assign w_inc = w_hs && r_is_pf;
  assign w_dec = pf_done && (r_cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_starve <= '0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_id     <= '0;
      r_is_pf  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_grant_p) begin
        r_addr  <= p_addr;
        r_len   <= p_len;
        r_id    <= p_id;
        r_is_pf <= 1'b1;
      end else if (w_grant_d) begin
        r_addr  <= d_addr;
        r_len   <= d_len;
        r_id    <= d_id;
        r_is_pf <= 1'b0;
      end
      if (ctrlFlush || w_grant_p) begin
        r_starve <= '0;
      end else if (w_grant_d && w_pf_elig && !w_starved) begin
        r_starve <= r_starve + SW'(1);
      end
      if (w_inc && !w_dec) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (w_dec && !w_inc) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prefetch_ar_arbiter.sv
// tb_prefetch_ar_arbiter: directed self-checking bench for prefetch_ar_arbiter.
`default_nettype none

module tb_prefetch_ar_arbiter;

  logic        clk = 1'b0;
  logic        reset, en, ctrlFlush;
  logic        d_valid, d_ready, p_valid, p_ready;
  logic [63:0] d_addr, p_addr, m_ar_addr;
  logic [7:0]  d_len, p_len, m_ar_len;
  logic [7:0]  d_id, p_id, m_ar_id;
  logic        m_ar_valid, m_ar_ready, m_ar_is_pf, pf_done;
  logic [6:0]  windowSize, pf_outstanding;

  int checks = 0;
  int errors = 0;
  int g, np;
  string exp_seq = "DDDDPDDDDP";
  byte got;

  always #5 clk = ~clk;

  prefetch_ar_arbiter dut (
    .clk(clk), .reset(reset), .en(en), .ctrlFlush(ctrlFlush),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_len(d_len), .d_id(d_id),
    .p_valid(p_valid), .p_ready(p_ready), .p_addr(p_addr), .p_len(p_len), .p_id(p_id),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
    .m_ar_len(m_ar_len), .m_ar_id(m_ar_id), .m_ar_is_pf(m_ar_is_pf),
    .pf_done(pf_done), .windowSize(windowSize), .pf_outstanding(pf_outstanding)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; en = 1'b0; ctrlFlush = 1'b0; pf_done = 1'b0;
    d_valid = 1'b1; d_addr = '0; d_len = '0; d_id = '0;
    p_valid = 1'b0; p_addr = '0; p_len = '0; p_id = '0;
    m_ar_ready = 1'b0; windowSize = 7'd3;
    repeat (2) step();
    chk("rst_valid", 64'(m_ar_valid), 64'd0);
    chk("rst_dready", 64'(d_ready), 64'd0);
    chk("rst_cnt", 64'(pf_outstanding), 64'd0);
    chk("rst_addr", m_ar_addr, 64'd0);

    // Single demand beat
    reset = 1'b0; en = 1'b1; m_ar_ready = 1'b1;
    d_addr = 64'hdeadbeef; d_len = 8'd4; d_id = 8'd3;
    settle();
    chk("d0_dready", 64'(d_ready), 64'd1);
    chk("d0_pready", 64'(p_ready), 64'd0);
    step();
    d_valid = 1'b0;
    chk("d1_valid", 64'(m_ar_valid), 64'd1);
    chk("d1_addr", m_ar_addr, 64'hdeadbeef);
    chk("d1_len", 64'(m_ar_len), 64'd4);
    chk("d1_id", 64'(m_ar_id), 64'd3);
    chk("d1_ispf", 64'(m_ar_is_pf), 64'd0);
    chk("d1_dready", 64'(d_ready), 64'd0);
    step();
    chk("d2_valid", 64'(m_ar_valid), 64'd0);
    d_valid = 1'b1; settle();
    chk("d2_idle", 64'(d_ready), 64'd1);
    d_valid = 1'b0; settle();

    en = 1'b0; d_valid = 1'b1; settle();
    chk("en0_dready", 64'(d_ready), 64'd0);
    en = 1'b1; d_valid = 1'b0; settle();

    // Starvation order with both requesters held
    d_valid = 1'b1; p_valid = 1'b1; p_addr = 64'hcafe0000; p_len = 8'd2; p_id = 8'd5;
    settle();
    g = 0;
    for (int cyc = 0; cyc < 40 && g < 10; cyc++) begin
      if (d_ready || p_ready) begin
        chk("mutex", 64'(d_ready & p_ready), 64'd0);
        got = d_ready ? "D" : "P";
        chk($sformatf("order%0d", g), 64'(got), 64'(exp_seq[g]));
        g++;
      end
      step();
    end
    chk("order_count", 64'(g), 64'd10);
    d_valid = 1'b0; p_valid = 1'b0;
    step();
    chk("order_cnt", 64'(pf_outstanding), 64'd2);

    pf_done = 1'b1;
    repeat (3) step();
    pf_done = 1'b0;
    chk("underflow", 64'(pf_outstanding), 64'd0);

    p_valid = 1'b1; ctrlFlush = 1'b1; settle();
    chk("flush_pready", 64'(p_ready), 64'd0);
    ctrlFlush = 1'b0; p_valid = 1'b0; settle();

    // Window limit
    p_valid = 1'b1; settle();
    np = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (p_ready) np++;
      step();
    end
    chk("win_grants", 64'(np), 64'd3);
    chk("win_cnt", 64'(pf_outstanding), 64'd3);
    chk("win_pready", 64'(p_ready), 64'd0);
    pf_done = 1'b1; step(); pf_done = 1'b0;
    np = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (p_ready) np++;
      step();
    end
    chk("win_regrant", 64'(np), 64'd1);
    chk("win_cnt2", 64'(pf_outstanding), 64'd3);

    // Window lowered below the count
    windowSize = 7'd2; pf_done = 1'b1; step(); pf_done = 1'b0;
    chk("low_pready0", 64'(p_ready), 64'd0);
    pf_done = 1'b1; step(); pf_done = 1'b0;
    chk("low_pready1", 64'(p_ready), 64'd1);
    p_valid = 1'b0; settle();

    // Stalled prefetch beat, with flush and demand arriving mid-beat
    windowSize = 7'd8; m_ar_ready = 1'b0;
    p_valid = 1'b1; p_addr = 64'h1234; p_len = 8'd7; p_id = 8'd9; settle();
    chk("stall_grant", 64'(p_ready), 64'd1);
    step();
    p_addr = 64'h5555; p_len = 8'd1; p_id = 8'd1; d_valid = 1'b1; ctrlFlush = 1'b1;
    settle();
    for (int cyc = 0; cyc < 5; cyc++) begin
      chk("stall_valid", 64'(m_ar_valid), 64'd1);
      chk("stall_addr", m_ar_addr, 64'h1234);
      chk("stall_len", 64'(m_ar_len), 64'd7);
      chk("stall_id", 64'(m_ar_id), 64'd9);
      chk("stall_ispf", 64'(m_ar_is_pf), 64'd1);
      chk("stall_ready", 64'({d_ready, p_ready}), 64'd0);
      step();
    end
    ctrlFlush = 1'b0; d_valid = 1'b0; p_valid = 1'b0; m_ar_ready = 1'b1;
    step();
    chk("stall_cnt", 64'(pf_outstanding), 64'd2);
    chk("stall_done", 64'(m_ar_valid), 64'd0);

    // Handshake and pf_done in the same cycle
    p_valid = 1'b1; settle();
    chk("coinc_grant", 64'(p_ready), 64'd1);
    step();
    p_valid = 1'b0; pf_done = 1'b1;
    step();
    pf_done = 1'b0;
    chk("coinc_cnt", 64'(pf_outstanding), 64'd2);

    // Reset during a demand beat
    d_valid = 1'b1; d_addr = 64'h77; m_ar_ready = 1'b0; settle();
    step();
    d_valid = 1'b0;
    chk("rstmid_valid", 64'(m_ar_valid), 64'd1);
    reset = 1'b1; settle();
    chk("rstmid_hold", 64'(m_ar_valid), 64'd0);
    step();
    reset = 1'b0; settle();
    chk("rstmid_after", 64'(m_ar_valid), 64'd0);
    chk("rstmid_cnt", 64'(pf_outstanding), 64'd0);
    chk("rstmid_addr", m_ar_addr, 64'd0);
    d_valid = 1'b1; settle();
    chk("rstmid_idle", 64'(d_ready), 64'd1);
    d_valid = 1'b0; settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
